// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encodings and stage control vectors for the hazard sequencer
package pipe_ctrl_pkg;

   localparam int REG_AW_DEF = 3;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MUL_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } ctrl_state_t;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_write;
      logic id_ex_bubble;
      logic ex_mem_write;
      logic ex_mem_bubble;
      logic mem_wb_bubble;
   } ctrl_vec_t;

   // Bubble/flush bits override the write enable of the same register.
   localparam ctrl_vec_t CV_NORMAL  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam ctrl_vec_t CV_LOADUSE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam ctrl_vec_t CV_BRANCH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam ctrl_vec_t CV_MULFRZ  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam ctrl_vec_t CV_MEMFRZ  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs from ID/EX/MEM and stage register controls
interface pipe_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
);
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rt;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_mem_read;
   logic              ex_reg_write;
   logic              ex_branch_taken;
   logic              ex_mul_op;
   logic              mem_busy;
   logic              pc_write;
   logic              if_id_write;
   logic              if_id_flush;
   logic              id_ex_write;
   logic              id_ex_bubble;
   logic              ex_mem_write;
   logic              ex_mem_bubble;
   logic              mem_wb_bubble;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read, ex_reg_write,
             ex_branch_taken, ex_mul_op, mem_busy,
      input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
             ex_mem_write, ex_mem_bubble, mem_wb_bubble
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read, ex_reg_write,
             ex_branch_taken, ex_mul_op, mem_busy,
      output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
             ex_mem_write, ex_mem_bubble, mem_wb_bubble
   );
endinterface

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - flags a load in EX whose result is read by the instruction in ID
module load_use_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_reg_write,
   output logic              load_use
);
   // Register 0 never carries a dependency.
   assign load_use = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for load-use, branch, multiply and memory waits
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW      = REG_AW_DEF,
   parameter int MUL_CYCLES  = 4,
   parameter int MEM_TIMEOUT = 64,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   pipe_ctrl_if.slave             bus,
   output logic [1:0]             ctrl_state,
   output logic                   mem_error,
   output logic [STALL_CNT_W-1:0] stall_cycles
);
   localparam int MUL_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
   localparam int MEM_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [MUL_W-1:0] MUL_LOAD = MUL_W'(MUL_CYCLES - 2);
   localparam logic [MEM_W-1:0] MEM_LAST = MEM_W'(MEM_TIMEOUT - 1);

   ctrl_state_t      state_q, state_d;
   logic [MUL_W-1:0] mul_cnt_q, mul_cnt_d;
   logic [MEM_W-1:0] mem_cnt_q;
   logic             load_use;
   ctrl_vec_t        cv;

   load_use_detect #(.REG_AW(REG_AW)) u_load_use (
      .id_rs        (bus.id_rs),
      .id_rt        (bus.id_rt),
      .id_uses_rt   (bus.id_uses_rt),
      .ex_rd        (bus.ex_rd),
      .ex_mem_read  (bus.ex_mem_read),
      .ex_reg_write (bus.ex_reg_write),
      .load_use     (load_use)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         mul_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         mul_cnt_q <= mul_cnt_d;
      end
   end

   // A busy memory freezes the multiply sequence; only the timeout can move the state.
   always_comb begin
      state_d   = state_q;
      mul_cnt_d = mul_cnt_q;
      if (state_q != ST_HALT) begin
         if (bus.mem_busy) begin
            if (mem_cnt_q == MEM_LAST) state_d = ST_HALT;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (bus.ex_mul_op && !bus.ex_branch_taken) begin
                     state_d   = ST_MUL_WAIT;
                     mul_cnt_d = MUL_LOAD;
                  end
               end
               ST_MUL_WAIT: begin
                  if (mul_cnt_q != '0) mul_cnt_d = mul_cnt_q - 1'b1;
                  else                 state_d   = ST_RUN;
               end
               default: state_d = ST_RUN;
            endcase
         end
      end
   end

   always_comb begin
      cv = CV_NORMAL;
      if (rst)                                              cv = CV_NORMAL;
      else if (state_q == ST_HALT || bus.mem_busy)          cv = CV_MEMFRZ;
      else if (state_q == ST_MUL_WAIT && mul_cnt_q != '0)   cv = CV_MULFRZ;
      else if (bus.ex_branch_taken)                         cv = CV_BRANCH;
      else if (state_q == ST_RUN && bus.ex_mul_op)          cv = CV_MULFRZ;
      else if (load_use)                                    cv = CV_LOADUSE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_cnt_q    <= '0;
         mem_error    <= 1'b0;
         stall_cycles <= '0;
      end else begin
         if (!bus.mem_busy)             mem_cnt_q <= '0;
         else if (mem_cnt_q != MEM_LAST) mem_cnt_q <= mem_cnt_q + 1'b1;
         if (state_q != ST_HALT && state_d == ST_HALT) mem_error <= 1'b1;
         if (!cv.pc_write && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      end
   end

   assign bus.pc_write      = cv.pc_write;
   assign bus.if_id_write   = cv.if_id_write;
   assign bus.if_id_flush   = cv.if_id_flush;
   assign bus.id_ex_write   = cv.id_ex_write;
   assign bus.id_ex_bubble  = cv.id_ex_bubble;
   assign bus.ex_mem_write  = cv.ex_mem_write;
   assign bus.ex_mem_bubble = cv.ex_mem_bubble;
   assign bus.mem_wb_bubble = cv.mem_wb_bubble;
   assign ctrl_state        = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - vector table plus multi-cycle sequences for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
   localparam int REG_AW      = 3;
   localparam int MUL_CYCLES  = 4;
   localparam int MEM_TIMEOUT = 64;
   localparam int STALL_CNT_W = 16;

   // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, ex_mem_bubble, mem_wb_bubble}
   localparam logic [7:0] V_NORMAL  = 8'b1101_0100;
   localparam logic [7:0] V_LOADUSE = 8'b0001_1100;
   localparam logic [7:0] V_BRANCH  = 8'b1111_1100;
   localparam logic [7:0] V_MULFRZ  = 8'b0000_0110;
   localparam logic [7:0] V_MEMFRZ  = 8'b0000_0001;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [1:0]             ctrl_state;
   logic                   mem_error;
   logic [STALL_CNT_W-1:0] stall_cycles;

   pipe_ctrl_if #(.REG_AW(REG_AW)) bus ();

   pipeline_hazard_ctrl #(
      .REG_AW      (REG_AW),
      .MUL_CYCLES  (MUL_CYCLES),
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .STALL_CNT_W (STALL_CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .ctrl_state   (ctrl_state),
      .mem_error    (mem_error),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] rs;
      logic [2:0] rt;
      logic       uses_rt;
      logic [2:0] rd;
      logic       mr;
      logic       rw;
      logic       br;
      logic       mul;
      logic       busy;
   } stim_t;

   typedef struct {
      stim_t      s;
      logic [7:0] ctrl;
   } vec_t;

   typedef struct {
      logic [7:0] ctrl;
      logic [1:0] st;
      logic       err;
   } exp_t;

   exp_t sbq[$];
   vec_t tbl[13];
   int   checks = 0;
   int   errors = 0;
   int   stall_exp = 0;

   function automatic stim_t mk(input int rs, input int rt, input int u, input int rd,
                                input int mr, input int rw, input int br, input int mul,
                                input int busy);
      stim_t s;
      s.rs = 3'(rs); s.rt = 3'(rt); s.uses_rt = (u != 0); s.rd = 3'(rd);
      s.mr = (mr != 0); s.rw = (rw != 0); s.br = (br != 0); s.mul = (mul != 0);
      s.busy = (busy != 0);
      return s;
   endfunction

   function automatic logic [7:0] ctrl_now();
      return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
              bus.id_ex_bubble, bus.ex_mem_write, bus.ex_mem_bubble, bus.mem_wb_bubble};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic drive(input stim_t s);
      bus.id_rs           = s.rs;
      bus.id_rt           = s.rt;
      bus.id_uses_rt      = s.uses_rt;
      bus.ex_rd           = s.rd;
      bus.ex_mem_read     = s.mr;
      bus.ex_reg_write    = s.rw;
      bus.ex_branch_taken = s.br;
      bus.ex_mul_op       = s.mul;
      bus.mem_busy        = s.busy;
   endtask

   // One clock: drive after the edge, push the expectation, compare at the falling edge.
   task automatic cyc(input stim_t s, input logic r, input logic [7:0] ectrl,
                      input logic [1:0] est, input logic eerr, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      drive(s);
      e.ctrl = ectrl; e.st = est; e.err = eerr;
      sbq.push_back(e);
      @(negedge clk);
      if (sbq.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s scoreboard empty", tag);
      end else begin
         e = sbq.pop_front();
         chk({tag, "_ctrl"},  32'(ctrl_now()),   32'(e.ctrl));
         chk({tag, "_state"}, 32'(ctrl_state),   32'(e.st));
         chk({tag, "_err"},   32'(mem_error),    32'(e.err));
         chk({tag, "_stall"}, 32'(stall_cycles), 32'(stall_exp));
      end
      if (r)                                          stall_exp = 0;
      else if (!ectrl[7] && stall_exp != 16'hFFFF)    stall_exp++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s_idle, s_mul, s_mulbusy, s_busy, s_lu;
      s_idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      s_mul     = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
      s_mulbusy = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
      s_busy    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
      s_lu      = mk(3, 0, 0, 3, 1, 1, 0, 0, 0);

      tbl[0]  = '{mk(3, 0, 0, 3, 1, 1, 0, 0, 0), V_LOADUSE};
      tbl[1]  = '{mk(0, 0, 0, 0, 1, 1, 0, 0, 0), V_NORMAL};
      tbl[2]  = '{mk(1, 5, 1, 5, 1, 1, 0, 0, 0), V_LOADUSE};
      tbl[3]  = '{mk(1, 5, 0, 5, 1, 1, 0, 0, 0), V_NORMAL};
      tbl[4]  = '{mk(3, 0, 0, 3, 0, 1, 0, 0, 0), V_NORMAL};
      tbl[5]  = '{mk(3, 0, 0, 3, 1, 0, 0, 0, 0), V_NORMAL};
      tbl[6]  = '{mk(3, 0, 0, 3, 1, 1, 1, 0, 0), V_BRANCH};
      tbl[7]  = '{mk(0, 0, 0, 0, 0, 1, 1, 1, 0), V_BRANCH};
      tbl[8]  = '{mk(3, 0, 0, 3, 1, 1, 0, 0, 1), V_MEMFRZ};
      tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 1), V_MEMFRZ};
      tbl[10] = '{mk(2, 4, 1, 3, 1, 1, 0, 0, 0), V_NORMAL};
      tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1), V_MEMFRZ};
      tbl[12] = '{mk(7, 7, 1, 7, 1, 1, 0, 0, 0), V_LOADUSE};

      rst = 1'b1;
      drive(s_idle);
      repeat (2) @(posedge clk);
      cyc(s_lu, 1'b1, V_NORMAL, 2'd0, 1'b0, "reset");

      for (int i = 0; i < 13; i++)
         cyc(tbl[i].s, 1'b0, tbl[i].ctrl, 2'd0, 1'b0, $sformatf("vec%0d", i));

      cyc(s_mul,  1'b0, V_MULFRZ, 2'd0, 1'b0, "mul0");
      cyc(s_mul,  1'b0, V_MULFRZ, 2'd1, 1'b0, "mul1");
      cyc(s_mul,  1'b0, V_MULFRZ, 2'd1, 1'b0, "mul2");
      cyc(s_mul,  1'b0, V_NORMAL, 2'd1, 1'b0, "mul3");
      cyc(s_idle, 1'b0, V_NORMAL, 2'd0, 1'b0, "mul4");

      cyc(s_mul,     1'b0, V_MULFRZ, 2'd0, 1'b0, "mwb0");
      cyc(s_mulbusy, 1'b0, V_MEMFRZ, 2'd1, 1'b0, "mwb1");
      cyc(s_mulbusy, 1'b0, V_MEMFRZ, 2'd1, 1'b0, "mwb2");
      cyc(s_mul,     1'b0, V_MULFRZ, 2'd1, 1'b0, "mwb3");
      cyc(s_mul,     1'b0, V_MULFRZ, 2'd1, 1'b0, "mwb4");
      cyc(s_mul,     1'b0, V_NORMAL, 2'd1, 1'b0, "mwb5");
      cyc(s_idle,    1'b0, V_NORMAL, 2'd0, 1'b0, "mwb6");

      cyc(s_mul,  1'b0, V_MULFRZ,  2'd0, 1'b0, "rmm0");
      cyc(s_mul,  1'b0, V_MULFRZ,  2'd1, 1'b0, "rmm1");
      cyc(s_mul,  1'b1, V_NORMAL,  2'd1, 1'b0, "rmm2");
      cyc(s_idle, 1'b0, V_NORMAL,  2'd0, 1'b0, "rmm3");
      cyc(s_lu,   1'b0, V_LOADUSE, 2'd0, 1'b0, "rmm4");
      cyc(s_idle, 1'b0, V_NORMAL,  2'd0, 1'b0, "rmm5");

      for (int k = 0; k < MEM_TIMEOUT; k++)
         cyc(s_busy, 1'b0, V_MEMFRZ, 2'd0, 1'b0, $sformatf("tmo%0d", k));
      cyc(s_idle, 1'b0, V_MEMFRZ,  2'd2, 1'b1, "halt0");
      cyc(s_lu,   1'b0, V_MEMFRZ,  2'd2, 1'b1, "halt1");
      cyc(s_idle, 1'b1, V_NORMAL,  2'd2, 1'b1, "hrst");
      cyc(s_idle, 1'b0, V_NORMAL,  2'd0, 1'b0, "post0");
      cyc(s_lu,   1'b0, V_LOADUSE, 2'd0, 1'b0, "post1");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
